// File: rtl/instr_prefetch.sv
// Instruction fetch front end: issues sequential reads to a 1-cycle synchronous
// imem, buffers responses in a small FIFO and feeds the IF/ID register.
module instr_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     id_stall,
  output logic [31:0]              if_id_instr,
  output logic [31:0]              if_id_npc,
  output logic                     if_id_valid,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   if_id_instr_q, if_id_instr_d;
  logic [31:0]   if_id_npc_q, if_id_npc_d;
  logic          if_id_valid_q, if_id_valid_d;

  logic [31:0]   fifo_instr_mem [DEPTH];
  logic [31:0]   fifo_npc_mem   [DEPTH];

  logic [CW:0]   credit_used;
  logic          push;
  logic          pop;

  // Credit counts the outstanding response so the FIFO can never overflow.
  assign credit_used = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign imem_req    = !reset && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc_q;
  assign push        = inflight_q && !redirect;
  assign pop         = !redirect && !id_stall && (count_q != '0);

  assign if_id_instr = if_id_instr_q;
  assign if_id_npc   = if_id_npc_q;
  assign if_id_valid = if_id_valid_q;
  assign occupancy   = count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_addr_d    = req_addr_q;
    inflight_d    = 1'b0;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if_id_instr_d = if_id_instr_q;
    if_id_npc_d   = if_id_npc_q;
    if_id_valid_d = if_id_valid_q;

    if (redirect) begin
      fetch_pc_d    = {redirect_pc[31:2], 2'b00};
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      if_id_instr_d = '0;
      if_id_npc_d   = '0;
      if_id_valid_d = 1'b0;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        req_addr_d = fetch_pc_q;
        inflight_d = 1'b1;
      end
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // A stalled decode keeps its current IF/ID value untouched.
      if (!id_stall) begin
        if (count_q != '0) begin
          if_id_instr_d = fifo_instr_mem[head_q];
          if_id_npc_d   = fifo_npc_mem[head_q];
          if_id_valid_d = 1'b1;
        end else begin
          if_id_instr_d = '0;
          if_id_npc_d   = '0;
          if_id_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
      req_addr_q    <= '0;
      inflight_q    <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      if_id_instr_q <= '0;
      if_id_npc_q   <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_addr_q    <= req_addr_d;
      inflight_q    <= inflight_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_npc_q   <= if_id_npc_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_instr_mem[tail_q] <= imem_rdata;
      fifo_npc_mem[tail_q]   <= req_addr_q + 32'd4;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == CW'(DEPTH))));

endmodule
